// File: rtl/output_process_spi.sv
// rtl/output_process_spi.sv - buffered 16-bit word serializer with address prefix and end-of-word strobe
//
// Purpose:
//   Words written into an internal DEPTH-deep buffer are sent one at a time as
//   19-bit frames {ADDR, word}, MSB first, followed by a one-bit-period load
//   strobe and a one-bit-period quiet gap.
//
// Ports:
//   SYS_CLK   in   1        single clock, rising edge
//   RST       in   1        synchronous active-high reset
//   WR_DATA   in   16       word to buffer
//   WR_REQ    in   1        write strobe for WR_DATA
//   FULL      out  1        buffer holds DEPTH words
//   USED      out  AW+1     words currently buffered
//   OVERFLOW  out  1        sticky: a write was dropped because the buffer was full
//   RX_STOP   in   1        far-end flow control, blocks the start of a new word
//   TX_CLK    out  1        serial clock (data valid on rising edge)
//   TX_DATA   out  1        serial data, MSB first
//   TX_LOAD   out  1        end-of-word strobe
//   BUSY      out  1        machine is not idle

module output_process_spi #(
   parameter logic [2:0] ADDR    = 3'b001,
   parameter int         CLK_DIV = 4,
   parameter int         DEPTH   = 256
) (
   input  logic                       SYS_CLK,
   input  logic                       RST,
   input  logic [15:0]                WR_DATA,
   input  logic                       WR_REQ,
   output logic                       FULL,
   output logic [$clog2(DEPTH):0]     USED,
   output logic                       OVERFLOW,
   input  logic                       RX_STOP,
   output logic                       TX_CLK,
   output logic                       TX_DATA,
   output logic                       TX_LOAD,
   output logic                       BUSY
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [AW:0]   USED_MAX = (AW+1)'(DEPTH);
   localparam logic [AW:0]   USED_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [4:0]    BIT_LAST = 5'd18;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      STROBE,
      GAP
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      div_q, div_d;
   logic            half_q, half_d;
   logic [4:0]      bit_q, bit_d;
   logic [18:0]     sh_q, sh_d;

   logic [15:0]     mem [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     used_q, used_d;
   logic            ovf_q, ovf_d;

   logic            full;
   logic            wr_en;
   logic            rd_en;
   logic            bit_end;

   // FULL is taken from the registered count, so a write in the same cycle
   // as a pop still sees a full buffer and is dropped.
   assign full    = (used_q == USED_MAX);
   assign wr_en   = WR_REQ && !full;
   assign rd_en   = (state_q == LOAD);
   // A bit ends on the last divider count of its high half.
   assign bit_end = (div_q == DIV_LAST) && half_q;

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      half_d   = half_q;
      bit_d    = bit_q;
      sh_d     = sh_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      used_d   = used_q;
      ovf_d    = ovf_q;

      if (WR_REQ && full) begin
         ovf_d = 1'b1;
      end
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({wr_en, rd_en})
         2'b10:   used_d = used_q + USED_ONE;
         2'b01:   used_d = used_q - USED_ONE;
         default: used_d = used_q;
      endcase

      // SHIFT, STROBE and GAP share the same bit-period timing.
      if (state_q == SHIFT || state_q == STROBE || state_q == GAP) begin
         if (div_q == DIV_LAST) begin
            div_d  = 8'd0;
            half_d = ~half_q;
         end else begin
            div_d  = div_q + 8'd1;
         end
      end

      case (state_q)
         IDLE: begin
            div_d  = 8'd0;
            half_d = 1'b0;
            bit_d  = 5'd0;
            if (used_q != '0 && !RX_STOP) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            sh_d    = {ADDR, mem[rd_ptr_q]};
            state_d = SHIFT;
         end
         SHIFT: begin
            if (bit_end) begin
               sh_d = {sh_q[17:0], 1'b0};
               if (bit_q == BIT_LAST) begin
                  bit_d   = 5'd0;
                  state_d = STROBE;
               end else begin
                  bit_d   = bit_q + 5'd1;
               end
            end
         end
         STROBE: begin
            if (bit_end) begin
               state_d = GAP;
            end
         end
         GAP: begin
            if (bit_end) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge SYS_CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         div_q    <= 8'd0;
         half_q   <= 1'b0;
         bit_q    <= 5'd0;
         sh_q     <= 19'd0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         used_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         half_q   <= half_d;
         bit_q    <= bit_d;
         sh_q     <= sh_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         used_q   <= used_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset: the pointers and count define which entries are live.
   always_ff @(posedge SYS_CLK) begin
      if (!RST && wr_en) begin
         mem[wr_ptr_q] <= WR_DATA;
      end
   end

   assign FULL     = full;
   assign USED     = used_q;
   assign OVERFLOW = ovf_q;
   // TX_CLK is gated off in GAP even though the divider keeps running there.
   assign TX_CLK   = (state_q == SHIFT || state_q == STROBE) && half_q;
   assign TX_DATA  = (state_q == SHIFT) && sh_q[18];
   assign TX_LOAD  = (state_q == STROBE);
   assign BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_output_process_spi.sv
// tb/tb_output_process_spi.sv - randomized scoreboard bench for output_process_spi
module tb_output_process_spi;

   localparam int         CLK_DIV  = 4;
   localparam int         DEPTH    = 16;
   localparam logic [2:0] ADDR     = 3'b001;
   localparam int         UW       = $clog2(DEPTH) + 1;
   localparam int         WORD_CYC = 1 + 21 * 2 * CLK_DIV;

   logic          SYS_CLK = 1'b0;
   logic          RST     = 1'b1;
   logic [15:0]   WR_DATA = 16'h0;
   logic          WR_REQ  = 1'b0;
   logic          RX_STOP = 1'b0;
   logic          FULL;
   logic [UW-1:0] USED;
   logic          OVERFLOW;
   logic          TX_CLK;
   logic          TX_DATA;
   logic          TX_LOAD;
   logic          BUSY;

   output_process_spi #(
      .ADDR    (ADDR),
      .CLK_DIV (CLK_DIV),
      .DEPTH   (DEPTH)
   ) dut (
      .SYS_CLK  (SYS_CLK),
      .RST      (RST),
      .WR_DATA  (WR_DATA),
      .WR_REQ   (WR_REQ),
      .FULL     (FULL),
      .USED     (USED),
      .OVERFLOW (OVERFLOW),
      .RX_STOP  (RX_STOP),
      .TX_CLK   (TX_CLK),
      .TX_DATA  (TX_DATA),
      .TX_LOAD  (TX_LOAD),
      .BUSY     (BUSY)
   );

   always #5 SYS_CLK = ~SYS_CLK;

   int checks = 0;
   int passed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: a word queue, a sticky overflow bit and a per-word
   // cycle counter (1 = LOAD cycle ... WORD_CYC = last cycle before idle).
   logic [15:0] mq[$];
   logic [15:0] exp_q[$];
   int          m_cnt     = 0;
   bit          m_ovf     = 0;
   bit          rst_seen  = 0;

   always @(posedge SYS_CLK) begin
      if (RST) begin
         mq.delete();
         exp_q.delete();
         m_cnt    = 0;
         m_ovf    = 0;
         rst_seen = 1;
      end else begin
         bit pop, accept, start;
         pop    = (m_cnt == 1);
         accept = WR_REQ && (mq.size() < DEPTH);
         if (WR_REQ && mq.size() == DEPTH) m_ovf = 1;
         start  = (m_cnt == 0) && (mq.size() > 0) && !RX_STOP;
         if (pop) exp_q.push_back(mq.pop_front());
         if (accept) mq.push_back(WR_DATA);
         if (m_cnt == 0) m_cnt = start ? 1 : 0;
         else if (m_cnt == WORD_CYC) m_cnt = 0;
         else m_cnt++;
      end
   end

   // Monitor: status checks every cycle plus a serial receiver that
   // rebuilds each frame and pops the scoreboard on the load strobe.
   logic [18:0] frame     = '0;
   int          bits      = 0;
   int          load_len  = 0;
   logic        prev_clk  = 0;
   logic        prev_data = 0;
   logic        prev_load = 0;

   always @(negedge SYS_CLK) begin
      check("used", 32'(USED), 32'(mq.size()));
      check("full", 32'(FULL), 32'(mq.size() == DEPTH));
      check("overflow", 32'(OVERFLOW), 32'(m_ovf));
      check("busy", 32'(BUSY), 32'(m_cnt != 0));
      if (m_cnt == 0) check("idle_outputs", 32'({TX_CLK, TX_DATA, TX_LOAD}), 32'h0);
      if (rst_seen) begin
         rst_seen = 0;
         bits     = 0;
         load_len = 0;
         frame    = '0;
      end else begin
         if (TX_CLK && prev_clk) check("data_stable_clk_high", 32'(TX_DATA), 32'(prev_data));
         if (TX_LOAD) check("strobe_data_low", 32'(TX_DATA), 32'h0);
         if (TX_CLK && !prev_clk && !TX_LOAD) begin
            frame = {frame[17:0], TX_DATA};
            bits++;
         end
         if (TX_LOAD) load_len++;
         if (TX_LOAD && !prev_load) begin
            check("frame_bits", 32'(bits), 32'd19);
            check("frame_addr", 32'(frame[18:16]), 32'(ADDR));
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_word actual=%0h expected=none at %0t", frame[15:0], $time);
            end else begin
               logic [15:0] e;
               e = exp_q.pop_front();
               check("frame_data", 32'(frame[15:0]), 32'(e));
            end
            bits = 0;
         end
         if (!TX_LOAD && prev_load) begin
            check("load_len", 32'(load_len), 32'(2 * CLK_DIV));
            load_len = 0;
         end
      end
      prev_clk  = TX_CLK;
      prev_data = TX_DATA;
      prev_load = TX_LOAD;
   end

   task automatic step();
      @(posedge SYS_CLK);
      #2;
   endtask

   task automatic wr(input logic [15:0] d);
      WR_REQ  = 1'b1;
      WR_DATA = d;
      step();
      WR_REQ  = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 30000; i++) begin
         if (mq.size() == 0 && m_cnt == 0) break;
         step();
      end
      check(name, 32'(mq.size() == 0 && m_cnt == 0), 32'h1);
   endtask

   task automatic wait_cnt(input string name, input int target);
      for (int i = 0; i < 2000; i++) begin
         if (m_cnt == target) break;
         step();
      end
      check(name, 32'(m_cnt), 32'(target));
   endtask

   initial begin
      RST = 1'b1;
      repeat (3) @(posedge SYS_CLK);
      #2;
      check("reset_used", 32'(USED), 32'h0);
      check("reset_outputs", 32'({FULL, OVERFLOW, TX_CLK, TX_DATA, TX_LOAD, BUSY}), 32'h0);
      RST = 1'b0;
      step();

      // Single known word.
      wr(16'hA5C3);
      wait_idle("single_word_drain");

      // Fill past capacity while stopped, then release.
      RX_STOP = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) wr(16'($urandom));
      repeat (3) step();
      check("fill_full", 32'(FULL), 32'h1);
      check("fill_overflow", 32'(OVERFLOW), 32'h1);
      check("fill_used", 32'(USED), 32'(DEPTH));
      RX_STOP = 1'b0;
      wait_idle("fill_drain");

      // Flow control raised mid-word.
      wr(16'($urandom));
      wr(16'($urandom));
      wait_cnt("stop_reach_bit5", 2 + 5 * 2 * CLK_DIV);
      RX_STOP = 1'b1;
      repeat (2 * WORD_CYC) step();
      check("stop_hold_used", 32'(USED), 32'h1);
      check("stop_hold_busy", 32'(BUSY), 32'h0);
      RX_STOP = 1'b0;
      wait_idle("stop_drain");

      // Reset mid-word, with a write presented during reset.
      wr(16'($urandom));
      wr(16'($urandom));
      wr(16'($urandom));
      wait_cnt("rst_reach_bit10", 2 + 10 * 2 * CLK_DIV);
      RST     = 1'b1;
      WR_REQ  = 1'b1;
      WR_DATA = 16'hBEEF;
      step();
      RST     = 1'b0;
      WR_REQ  = 1'b0;
      check("rst_mid_used", 32'(USED), 32'h0);
      check("rst_mid_outputs", 32'({TX_CLK, TX_DATA, TX_LOAD, BUSY, OVERFLOW}), 32'h0);
      repeat (2 * WORD_CYC) step();

      // Continuous random traffic across many pointer wraps.
      for (int i = 0; i < 6000; i++) begin
         WR_REQ  = 1'($urandom_range(0, 1));
         WR_DATA = 16'($urandom);
         RX_STOP = ($urandom_range(0, 15) == 0);
         step();
      end
      WR_REQ  = 1'b0;
      RX_STOP = 1'b0;
      wait_idle("stream_drain");
      repeat (4) step();
      check("all_words_emitted", 32'(exp_q.size()), 32'h0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
